// File: rtl/conv33_window_gen.sv
// conv33_window_gen: streaming 3x3 sliding-window generator.
// Two line buffers plus a column history feed one registered window stage.
module conv33_window_gen #(
    parameter int DATA_W = 6,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DATA_W-1:0] win_0,
    output logic [DATA_W-1:0] win_1,
    output logic [DATA_W-1:0] win_2,
    output logic [DATA_W-1:0] win_3,
    output logic [DATA_W-1:0] win_4,
    output logic [DATA_W-1:0] win_5,
    output logic [DATA_W-1:0] win_6,
    output logic [DATA_W-1:0] win_7,
    output logic [DATA_W-1:0] win_8,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    // lb0 holds row r-2, lb1 holds row r-1 at each column.
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;

    // hist[row][0] is column c-2, hist[row][1] is column c-1.
    // Together with the incoming column they form the window.
    logic [DATA_W-1:0] hist [3][2];

    logic [DATA_W-1:0] win_q  [9];
    logic [DATA_W-1:0] win_nx [9];

    logic              accept;
    logic              col_last;
    logic              row_last;
    logic              in_window;
    logic              emit;
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;

    assign pix_ready = !win_valid || win_ready;
    assign accept    = pix_valid && pix_ready;

    assign col_last  = (col_cnt == COL_LAST);
    assign row_last  = (row_cnt == ROW_LAST);
    assign in_window = (row_cnt >= ROW_MIN) && (col_cnt >= COL_MIN);
    assign emit      = accept && in_window;

    assign lb0_rd = lb0[col_cnt];
    assign lb1_rd = lb1[col_cnt];

    // Assemble the window formed by the history and the incoming column.
    always_comb begin
        win_nx[0] = hist[0][0];
        win_nx[1] = hist[0][1];
        win_nx[2] = lb0_rd;
        win_nx[3] = hist[1][0];
        win_nx[4] = hist[1][1];
        win_nx[5] = lb1_rd;
        win_nx[6] = hist[2][0];
        win_nx[7] = hist[2][1];
        win_nx[8] = pix_in;
    end

    // Line buffers: read-before-write, lb1 entry ages into lb0.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col_cnt] <= lb1_rd;
            lb1[col_cnt] <= pix_in;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_cnt <= '0;
                if (row_last) begin
                    row_cnt <= '0;
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                end
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Column history shifts left by one column per accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                hist[r][0] <= '0;
                hist[r][1] <= '0;
            end
        end else if (accept) begin
            hist[0][0] <= hist[0][1];
            hist[1][0] <= hist[1][1];
            hist[2][0] <= hist[2][1];
            hist[0][1] <= lb0_rd;
            hist[1][1] <= lb1_rd;
            hist[2][1] <= pix_in;
        end
    end

    // Output stage: load on emit, hold under backpressure, drop on take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
            win_valid <= 1'b0;
        end else if (emit) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_nx[i];
            end
            win_valid <= 1'b1;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

    // Frame-end pulse aligned with the last window's first valid cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= emit && row_last && col_last;
        end
    end

    assign win_0 = win_q[0];
    assign win_1 = win_q[1];
    assign win_2 = win_q[2];
    assign win_3 = win_q[3];
    assign win_4 = win_q[4];
    assign win_5 = win_q[5];
    assign win_6 = win_q[6];
    assign win_7 = win_q[7];
    assign win_8 = win_q[8];

endmodule
